barrel_shifter_pipelined: RTL and testbench
===========================================

Name: barrel_shifter_pipelined

Overview:
Parametrised, pipelined multi-mode barrel shifter with a valid/ready stream interface on input and output. It supports logical left/right with a selectable pad value, arithmetic right, and left/right rotate. Shift levels are grouped into registered stages so the block closes timing at wide DATA_WIDTH. It sits in datapaths such as FPU alignment, packet field extraction and ALUs where a combinational shifter is too slow.

Parameters:
DATA_WIDTH, 8, data width in bits; power of two, >= 2.
SHIFT_WIDTH, $clog2(DATA_WIDTH), width of the shift amount.
LEVELS_PER_STAGE, 1, mux levels (shift bits) per register stage; legal range 1..SHIFT_WIDTH.

Ports:
clock  input  1  clock, rising edge.
reset  input  1  synchronous active-high reset.
input_valid  input  1  input transaction valid.
input_ready  output  1  block accepts input this cycle.
data_in  input  DATA_WIDTH  data to shift.
shift  input  SHIFT_WIDTH  shift amount, 0..DATA_WIDTH-1.
mode  input  3  operation select.
pad_value  input  1  fill bit for logical shifts.
output_valid  output  1  result valid.
output_ready  input  1  downstream accepts result.
data_out  output  DATA_WIDTH  shifted result.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset clears every stage valid and stage data register. After reset: output_valid=0, data_out=0, input_ready=1.
- Mode encoding:
  - 000: logical right, vacated MSBs filled with pad_value.
  - 001: logical left, vacated LSBs filled with pad_value.
  - 010: arithmetic right, filled with data_in[MSB]; pad_value ignored.
  - 011: rotate right.
  - 100: rotate left.
  - 101..111: reserved, data passes unchanged (shift treated as 0).
- Mux levels: level k shifts by 2^k when shift[k]=1, LSB level first.
- Left modes are implemented as bit-reverse, right shift, bit-reverse. The mode, shift bits and fill bit travel with the data through the pipeline.
- Stage grouping: stage s holds levels s*LEVELS_PER_STAGE to min((s+1)*LEVELS_PER_STAGE, SHIFT_WIDTH)-1. Each stage is registered.
- Number of stages N = ceil(SHIFT_WIDTH/LEVELS_PER_STAGE). Latency: a result accepted at edge t is visible with output_valid=1 after edge t+N-1, i.e. N cycles from acceptance to output.
- Handshake:
  - Input is accepted on a clock edge when input_valid && input_ready.
  - Output completes when output_valid && output_ready.
  - Global stall: advance = !output_valid || output_ready. On advance all stages shift forward one step; input_ready = advance (combinational).
  - Bubbles are not compressed.
- Throughput is 1 transaction per cycle while output_ready=1.
- While output_valid && !output_ready: data_out and all stage contents hold stable.
- Ordering is strictly in order; no drop, no duplication.
- input_valid=0 on an advance cycle inserts a bubble (stage valid=0). Bubble stage data is don't-care but deterministic (registers hold).
- Reset mid-operation: all in-flight transactions are discarded; output_valid=0 on the cycle after reset is sampled high.
- shift=0 in any mode gives data_out=data_in.

Optional Feature:
Macro BARREL_SHIFTER_PIPELINED_STICKY_EN.
- Defined: adds output port sticky (1 bit), valid alongside data_out.
  - Logical and arithmetic modes: sticky = OR of all data_in bits shifted out of the word.
  - Rotate and reserved modes: sticky = 0.
  - Sticky is accumulated per level, carried through the stages, and reset to 0.
- Not defined: port absent and no sticky registers; all other behaviour identical.

Test Plan:
(Bench uses DATA_WIDTH=8, LEVELS_PER_STAGE=1, so N=3.)
1. Reset: assert reset for 2 cycles with input_valid=1 -> output_valid=0, data_out=0x00, input_ready=1; nothing emerges after release until a new accept.
2. Modes, output_ready=1, single transactions, result 3 cycles after accept:
   - mode=000, data 0xB0, shift 3, pad 1 -> 0xF6.
   - mode=001, data 0x81, shift 4, pad 1 -> 0x1F.
   - mode=010, data 0x90, shift 2 -> 0xE4.
   - mode=011, data 0x01, shift 1 -> 0x80.
   - mode=100, data 0x81, shift 1 -> 0x03.
   - mode=111, data 0x5A, shift 5 -> 0x5A.
3. Streaming: 8 back-to-back accepts (mode=000, pad 0, data 0x80, shift 0..7) -> outputs 0x80,0x40,...,0x01 on 8 consecutive cycles starting 3 cycles after the first accept.
4. Backpressure: stream 6 transactions, drop output_ready low for 4 cycles mid-stream -> input_ready=0 while stalled, data_out stable, all 6 results in order exactly once.
5. Reset mid-flight: 3 transactions in flight, pulse reset 1 cycle -> output_valid=0 next cycle; no stale result ever appears.
6. Sticky (macro defined):
   - mode=000, 0x0B, shift 2 -> data_out 0x02, sticky=1.
   - mode=000, 0x0C, shift 2 -> data_out 0x03, sticky=0.
   - mode=011, 0x0B, shift 2 -> sticky=0.

Source files
------------

// File: rtl/barrel_shifter_pipelined.sv
// Pipelined multi-mode barrel shifter with valid/ready handshake and a global stall.
// Optional sticky output (OR of shifted-out bits) enabled by BARREL_SHIFTER_PIPELINED_STICKY_EN.
module barrel_shifter_pipelined #(
    parameter int DATA_WIDTH       = 8,
    parameter int SHIFT_WIDTH      = $clog2(DATA_WIDTH),
    parameter int LEVELS_PER_STAGE = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [2:0]             mode,
    input  logic                   pad_value,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [DATA_WIDTH-1:0]  data_out
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
    ,
    output logic                   sticky
`endif
);

    localparam int NUM_STAGES = (SHIFT_WIDTH + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    function automatic logic [DATA_WIDTH-1:0] reverse_bits(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = x[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_right_fill(input logic [DATA_WIDTH-1:0] x,
                                                               input logic fill, input int amt);
        logic [DATA_WIDTH-1:0] ones;
        ones = '1;
        return (x >> amt) | (fill ? ~(ones >> amt) : '0);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rotate_right(input logic [DATA_WIDTH-1:0] x,
                                                           input int amt);
        return (x >> amt) | (x << (DATA_WIDTH - amt));
    endfunction

`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
    function automatic logic low_bits_any(input logic [DATA_WIDTH-1:0] x, input int amt);
        logic [DATA_WIDTH-1:0] ones;
        ones = '1;
        return |(x & ~(ones << amt));
    endfunction
`endif

    logic advance;

    // Global stall: every stage moves together, bubbles included.
    assign advance     = !output_valid || output_ready;
    assign input_ready = advance;

    // Per-stage inputs; index 0 is fed by the front-end decode.
    logic [DATA_WIDTH-1:0]  stage_data_in   [NUM_STAGES];
    logic                   stage_valid_in  [NUM_STAGES];
    logic [SHIFT_WIDTH-1:0] stage_shift_in  [NUM_STAGES];
    logic                   stage_rotate_in [NUM_STAGES];
    logic                   stage_fill_in   [NUM_STAGES];
    logic                   stage_left_in   [NUM_STAGES];
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
    logic                   stage_sticky_in [NUM_STAGES];
`endif

    logic                   mode_left;
    logic                   mode_rotate;
    logic                   mode_reserved;
    logic                   fill_in;
    logic [SHIFT_WIDTH-1:0] shift_in;
    logic [DATA_WIDTH-1:0]  data_pre;

    // Left modes run through the right-shift datapath on a bit-reversed word.
    always_comb begin
        mode_left     = (mode == 3'b001) || (mode == 3'b100);
        mode_rotate   = (mode == 3'b011) || (mode == 3'b100);
        mode_reserved = (mode > 3'b100);
        fill_in       = (mode == 3'b010) ? data_in[DATA_WIDTH-1] : pad_value;
        shift_in      = mode_reserved ? '0 : shift;
        data_pre      = mode_left ? reverse_bits(data_in) : data_in;
    end

    assign stage_data_in[0]   = data_pre;
    assign stage_valid_in[0]  = input_valid;
    assign stage_shift_in[0]  = shift_in;
    assign stage_rotate_in[0] = mode_rotate;
    assign stage_fill_in[0]   = fill_in;
    assign stage_left_in[0]   = mode_left;
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
    assign stage_sticky_in[0] = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            localparam int LO = gi * LEVELS_PER_STAGE;
            localparam int HI = ((gi + 1) * LEVELS_PER_STAGE < SHIFT_WIDTH) ?
                                (gi + 1) * LEVELS_PER_STAGE : SHIFT_WIDTH;

            logic [DATA_WIDTH-1:0]  data_next;
            logic [SHIFT_WIDTH-1:0] shift_next;
            logic [DATA_WIDTH-1:0]  data_reg;
            logic                   valid_reg;
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
            logic                   sticky_next;
            logic                   sticky_reg;
`endif

            // Consumed shift bits are shifted out so the next stage always tests bit 0.
            always_comb begin
                data_next  = stage_data_in[gi];
                shift_next = stage_shift_in[gi];
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
                sticky_next = stage_sticky_in[gi];
`endif
                for (int k = LO; k < HI; k++) begin
                    if (shift_next[0]) begin
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
                        sticky_next = sticky_next ||
                                      (!stage_rotate_in[gi] && low_bits_any(data_next, 1 << k));
`endif
                        data_next = stage_rotate_in[gi] ? rotate_right(data_next, 1 << k)
                                  : shift_right_fill(data_next, stage_fill_in[gi], 1 << k);
                    end
                    shift_next = shift_next >> 1;
                end
                if (gi == NUM_STAGES - 1 && stage_left_in[gi]) begin
                    data_next = reverse_bits(data_next);
                end
            end

            // Bubbles advance the valid bit only; payload registers hold.
            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_reg  <= 1'b0;
                    data_reg   <= '0;
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
                    sticky_reg <= 1'b0;
`endif
                end else if (advance) begin
                    valid_reg <= stage_valid_in[gi];
                    if (stage_valid_in[gi]) begin
                        data_reg   <= data_next;
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
                        sticky_reg <= sticky_next;
`endif
                    end
                end
            end

            if (gi < NUM_STAGES - 1) begin : g_fwd
                logic [SHIFT_WIDTH-1:0] shift_reg;
                logic                   rotate_reg;
                logic                   fill_reg;
                logic                   left_reg;

                always_ff @(posedge clock) begin
                    if (reset) begin
                        shift_reg  <= '0;
                        rotate_reg <= 1'b0;
                        fill_reg   <= 1'b0;
                        left_reg   <= 1'b0;
                    end else if (advance && stage_valid_in[gi]) begin
                        shift_reg  <= shift_next;
                        rotate_reg <= stage_rotate_in[gi];
                        fill_reg   <= stage_fill_in[gi];
                        left_reg   <= stage_left_in[gi];
                    end
                end

                assign stage_data_in[gi+1]   = data_reg;
                assign stage_valid_in[gi+1]  = valid_reg;
                assign stage_shift_in[gi+1]  = shift_reg;
                assign stage_rotate_in[gi+1] = rotate_reg;
                assign stage_fill_in[gi+1]   = fill_reg;
                assign stage_left_in[gi+1]   = left_reg;
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
                assign stage_sticky_in[gi+1] = sticky_reg;
`endif
            end else begin : g_out
                assign output_valid = valid_reg;
                assign data_out     = data_reg;
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
                assign sticky       = sticky_reg;
`endif
            end
        end
    endgenerate

endmodule

// File: tb/tb_barrel_shifter_pipelined.sv
// Self-checking bench for barrel_shifter_pipelined (DATA_WIDTH=8, one level per stage, 3 stages).
// Compares against a per-bit reference model; sticky checks compile in with BARREL_SHIFTER_PIPELINED_STICKY_EN.
module tb_barrel_shifter_pipelined;

    localparam int W = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       input_valid;
    logic       input_ready;
    logic [7:0] data_in;
    logic [2:0] shift;
    logic [2:0] mode;
    logic       pad_value;
    logic       output_valid;
    logic       output_ready;
    logic [7:0] data_out;
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
    logic       sticky;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       stk;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [7:0] DIR_DATA  [6] = '{8'hB0, 8'h81, 8'h90, 8'h01, 8'h81, 8'h5A};
    localparam logic [2:0] DIR_SHIFT [6] = '{3'd3, 3'd4, 3'd2, 3'd1, 3'd1, 3'd5};
    localparam logic [2:0] DIR_MODE  [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    localparam logic       DIR_PAD   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] DIR_EXP   [6] = '{8'hF6, 8'h1F, 8'hE4, 8'h80, 8'h03, 8'h5A};

    barrel_shifter_pipelined #(
        .DATA_WIDTH(8),
        .LEVELS_PER_STAGE(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .input_valid(input_valid),
        .input_ready(input_ready),
        .data_in(data_in),
        .shift(shift),
        .mode(mode),
        .pad_value(pad_value),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .data_out(data_out)
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
        ,
        .sticky(sticky)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Reference: each output bit picks its source bit by the mode's rule.
    function automatic logic [7:0] model_data(input logic [7:0] d, input int s,
                                              input logic [2:0] m, input logic p);
        logic [7:0] r;
        r = d;
        if (m > 3'd4) return d;
        for (int i = 0; i < W; i++) begin
            case (m)
                3'd0:    r[i] = (i + s < W) ? d[i + s] : p;
                3'd1:    r[i] = (i - s >= 0) ? d[i - s] : p;
                3'd2:    r[i] = (i + s < W) ? d[i + s] : d[W-1];
                3'd3:    r[i] = d[(i + s) % W];
                default: r[i] = d[(i + W - s) % W];
            endcase
        end
        return r;
    endfunction

    function automatic logic model_sticky(input logic [7:0] d, input int s, input logic [2:0] m);
        logic any;
        any = 1'b0;
        for (int j = 0; j < W; j++) begin
            if ((m == 3'd0 || m == 3'd2) && j < s) any = any | d[j];
            if (m == 3'd1 && j >= W - s) any = any | d[j];
        end
        return any;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        input_valid  = 1'b1;
        output_ready = 1'b1;
        data_in      = 8'hA5;
        shift        = 3'd1;
        mode         = 3'd0;
        pad_value    = 1'b1;
        tick();
        tick();
        tests_run++;
        if (output_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: actual=%b required=0", output_valid);
        end
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data: actual=%h required=00", data_out);
        end
        tests_run++;
        if (input_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: actual=%b required=1", input_ready);
        end
        reset       = 1'b0;
        input_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests_run++;
            if (output_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_idle cycle %0d: actual=%b required=0", c, output_valid);
            end
        end
        $display("[TB] reset: checked");
    endtask

    // Single isolated transactions: 6 directed, then random ones from the model.
    task automatic test_modes();
        logic [7:0] exp_d;
        logic       exp_s;
        output_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 6) begin
                data_in   = DIR_DATA[i];
                shift     = DIR_SHIFT[i];
                mode      = DIR_MODE[i];
                pad_value = DIR_PAD[i];
                exp_d     = DIR_EXP[i];
            end else begin
                data_in   = 8'($urandom);
                shift     = 3'($urandom_range(0, 7));
                mode      = 3'($urandom_range(0, 7));
                pad_value = 1'($urandom_range(0, 1));
                exp_d     = model_data(data_in, int'(shift), mode, pad_value);
            end
            exp_s       = model_sticky(data_in, int'(shift), mode);
            input_valid = 1'b1;
            #1;
            tests_run++;
            if (input_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL modes_ready #%0d: actual=%b required=1", i, input_ready);
            end
            tick();
            input_valid = 1'b0;
            tick();
            tests_run++;
            if (output_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL modes_early #%0d: actual=%b required=0", i, output_valid);
            end
            tick();
            tests_run++;
            if (output_valid !== 1'b1 || data_out !== exp_d) begin
                tests_failed++;
                $display("FAIL modes #%0d mode=%0d shift=%0d: actual valid=%b data=%h required valid=1 data=%h",
                         i, mode, shift, output_valid, data_out, exp_d);
            end
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
            tests_run++;
            if (sticky !== exp_s) begin
                tests_failed++;
                $display("FAIL modes_sticky #%0d: actual=%b required=%b", i, sticky, exp_s);
            end
`endif
            $display("[TB] modes #%0d: mode=%0d data=%h shift=%0d pad=%b -> %h (ref %h, sticky ref %b)",
                     i, mode, data_in, shift, pad_value, data_out, exp_d, exp_s);
            tick();
        end
    endtask

`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
    task automatic test_sticky();
        logic [7:0] sd [3];
        logic [2:0] sm [3];
        logic [7:0] se [3];
        logic       ss [3];
        sd = '{8'h0B, 8'h0C, 8'h0B};
        sm = '{3'b000, 3'b000, 3'b011};
        se = '{8'h02, 8'h03, 8'hC2};
        ss = '{1'b1, 1'b0, 1'b0};
        output_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in     = sd[i];
            mode        = sm[i];
            shift       = 3'd2;
            pad_value   = 1'b0;
            input_valid = 1'b1;
            tick();
            input_valid = 1'b0;
            tick();
            tick();
            tests_run++;
            if (output_valid !== 1'b1 || data_out !== se[i] || sticky !== ss[i]) begin
                tests_failed++;
                $display("FAIL sticky #%0d: actual valid=%b data=%h sticky=%b required valid=1 data=%h sticky=%b",
                         i, output_valid, data_out, sticky, se[i], ss[i]);
            end
            $display("[TB] sticky #%0d: data=%h -> %h sticky=%b", i, sd[i], data_out, sticky);
            tick();
        end
    endtask
`endif

    task automatic test_back_to_back();
        output_ready = 1'b1;
        mode         = 3'd0;
        pad_value    = 1'b0;
        data_in      = 8'h80;
        for (int c = 0; c < 12; c++) begin
            input_valid = (c < 8);
            shift       = 3'(c);
            tick();
            tests_run++;
            if (c >= 2 && c < 10) begin
                if (output_valid !== 1'b1 || data_out !== (8'h80 >> (c - 2))) begin
                    tests_failed++;
                    $display("FAIL stream cycle %0d: actual valid=%b data=%h required valid=1 data=%h",
                             c, output_valid, data_out, 8'h80 >> (c - 2));
                end
                $display("[TB] stream: out %0d = %h", c - 2, data_out);
            end else if (output_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stream_idle cycle %0d: actual=%b required=0", c, output_valid);
            end
        end
        input_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int         sent     = 0;
        int         received = 0;
        logic       stalled  = 1'b0;
        logic [7:0] held     = 8'h00;
        exp_t       e;
        exp_q.delete();
        for (int c = 0; c < 40 && received < 6; c++) begin
            input_valid  = (sent < 6);
            data_in      = 8'($urandom);
            shift        = 3'($urandom_range(0, 7));
            mode         = 3'($urandom_range(0, 7));
            pad_value    = 1'($urandom_range(0, 1));
            output_ready = !(c >= 4 && c < 8);
            #1;
            if (stalled) begin
                tests_run++;
                if (output_valid !== 1'b1 || data_out !== held) begin
                    tests_failed++;
                    $display("FAIL bp_hold cycle %0d: actual valid=%b data=%h required valid=1 data=%h",
                             c, output_valid, data_out, held);
                end
            end
            tests_run++;
            if (input_ready !== (!output_valid || output_ready)) begin
                tests_failed++;
                $display("FAIL bp_ready cycle %0d: actual=%b required=%b",
                         c, input_ready, !output_valid || output_ready);
            end
            if (input_valid && input_ready) begin
                exp_q.push_back('{model_data(data_in, int'(shift), mode, pad_value),
                                  model_sticky(data_in, int'(shift), mode)});
                sent++;
            end
            if (output_valid && output_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL bp_extra: actual data=%h required=no output", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out !== e.data) begin
                        tests_failed++;
                        $display("FAIL bp_data #%0d: actual=%h required=%h", received, data_out, e.data);
                    end
                    $display("[TB] backpressure: result %0d = %h (ref %h)", received, data_out, e.data);
                end
                received++;
            end
            stalled = output_valid && !output_ready;
            held    = data_out;
            tick();
        end
        input_valid  = 1'b0;
        output_ready = 1'b1;
        tests_run++;
        if (received != 6 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_count: actual received=%0d pending=%0d required received=6 pending=0",
                     received, exp_q.size());
        end
    endtask

    task automatic test_random();
        int   received = 0;
        exp_t e;
        exp_q.delete();
        for (int c = 0; c < 300; c++) begin
            input_valid  = (c < 250) && ($urandom_range(0, 3) != 0);
            data_in      = 8'($urandom);
            shift        = 3'($urandom_range(0, 7));
            mode         = 3'($urandom_range(0, 7));
            pad_value    = 1'($urandom_range(0, 1));
            output_ready = (c >= 250) || ($urandom_range(0, 3) != 0);
            #1;
            if (input_valid && input_ready) begin
                exp_q.push_back('{model_data(data_in, int'(shift), mode, pad_value),
                                  model_sticky(data_in, int'(shift), mode)});
            end
            if (output_valid && output_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_extra cycle %0d: actual data=%h required=no output", c, data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out !== e.data) begin
                        tests_failed++;
                        $display("FAIL rand_data #%0d: actual=%h required=%h", received, data_out, e.data);
                    end
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
                    if (sticky !== e.stk) begin
                        tests_failed++;
                        $display("FAIL rand_sticky #%0d: actual=%b required=%b", received, sticky, e.stk);
                    end
`endif
                    $display("[TB] random: result %0d = %h (ref %h)", received, data_out, e.data);
                end
                received++;
            end
            tick();
        end
        input_valid = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_drain: actual pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        output_ready = 1'b1;
        mode         = 3'd3;
        pad_value    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            input_valid = 1'b1;
            data_in     = 8'($urandom);
            shift       = 3'($urandom_range(0, 7));
            tick();
        end
        input_valid = 1'b0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (output_valid !== 1'b0 || data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL midreset: actual valid=%b data=%h required valid=0 data=00",
                     output_valid, data_out);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            tests_run++;
            if (output_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL midreset_stale cycle %0d: actual=%b required=0", c, output_valid);
            end
        end
        $display("[TB] reset mid-flight: checked");
    endtask

    initial begin
        test_reset();
        test_modes();
`ifdef BARREL_SHIFTER_PIPELINED_STICKY_EN
        test_sticky();
`endif
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
